mc_cu: RTL
==========

Name: mc_cu

Overview:
- Multi-cycle successor to the single-cycle MIPS32 control unit.
- Same instruction subset: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal.
- Sequences each instruction through an IF/ID/EXE/MEM/WB state machine over a shared datapath with one memory port.
- Adds a memory ready handshake, a memory-wait watchdog, illegal-opcode detection and a retired-instruction counter.

Parameters:
- CNT_W, 32: width of retired-instruction counter.
- MEM_HANDSHAKE, 1: 1 = wait for mem_rdy; 0 = mem_rdy ignored, memory treated as single-cycle.
- TMO_W, 4: watchdog width; timeout after 2^TMO_W-1 wait cycles with mem_req high and mem_rdy low.

Ports:
- clock, in, 1: rising-edge clock.
- resetn, in, 1: asynchronous active-low reset.
- op, in, 6: IR[31:26], stable from ID until return to IF.
- func, in, 6: IR[5:0].
- z, in, 1: ALU zero flag, combinational from the current-cycle ALU result.
- mem_rdy, in, 1: memory completes the access this cycle.
- mem_req, out, 1: memory access request.
- iord, out, 1: 0 = address from PC, 1 = address from ALU register.
- wmem, out, 1: memory write strobe.
- wir, out, 1: IR load enable.
- wpc, out, 1: PC load enable.
- wreg, out, 1: register-file write enable.
- regrt, m2reg, shift, sext, jal, out, 1 each: same meaning as the single-cycle unit.
- alusrca, out, 1: 0 = PC, 1 = register A or shift amount.
- alusrcb, out, 2: 00 = reg B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- aluc, out, 4: ALU op. add 0000, sub x100, and x001, or x101, xor x010, lui x110, sll 0011, srl 0111, sra 1111.
- pcsource, out, 2: 00 = ALU result (PC+4), 01 = branch target register, 10 = register rs (jr), 11 = jump address.
- state, out, 3: IF=0, ID=1, EXE=2, MEM=3, WB=4.
- ill, out, 1: one-cycle pulse on an illegal opcode.
- tmo, out, 1: one-cycle pulse on a watchdog expiry.
- icount, out, CNT_W: count of retired instructions.

Behaviour:
- Reset (resetn=0, asynchronous): state=IF, icount=0, watchdog=0. While resetn=0, every output is forced to 0: mem_req, wmem, wir, wpc, wreg, ill, tmo.
- Outputs are combinational from state, op, func, z and mem_rdy. Only the state, watchdog and icount are registered.
- Any output not listed for a state is 0.
- IF:
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - On mem_rdy: wir=1, wpc=1, go to ID.
  - Otherwise hold in IF.
- ID:
  - alusrca=0, alusrcb=11, aluc=add (branch target latched externally).
  - j: wpc=1, pcsource=11; retire; go to IF.
  - jal: same as j, plus wreg=1, jal=1.
  - jr: wpc=1, pcsource=10; retire; go to IF.
  - Undefined op or func: ill=1, no write enables; go to IF, no retire.
  - All other instructions: go to EXE.
- EXE:
  - alusrca=1. alusrcb=00 for R-type and branches, 10 for I-type and lw/sw. aluc per the table.
  - beq/bne use aluc=sub. If (beq&z) or (bne&~z): wpc=1, pcsource=01. Retire either way; go to IF.
  - lw/sw: aluc=add, go to MEM. All others go to WB.
- MEM:
  - mem_req=1, iord=1.
  - sw: wmem=1 while in MEM. On mem_rdy: retire, go to IF.
  - lw: on mem_rdy go to WB.
- WB:
  - wreg=1. regrt and m2reg per the single-cycle rules.
  - Retire; go to IF.
- Retire: icount increments by 1 on the cycle the FSM leaves toward IF (WB, EXE-branch, MEM-sw, ID-jump). icount wraps modulo 2^CNT_W.
- Watchdog:
  - Counts cycles where mem_req=1 and mem_rdy=0; clears on any other cycle.
  - On reaching 2^TMO_W-1: tmo=1 for one cycle, all write enables 0 that cycle, go to IF, watchdog cleared, no retire.
- MEM_HANDSHAKE=0: mem_rdy treated as 1 and the watchdog is disabled (tmo tied 0).
- Mid-operation reset: the access is abandoned; the FSM restarts in IF after resetn rises.
- No state ever asserts both wmem and wreg.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and func constants;
  - the aluc encoding constants;
  - the FSM state encoding;
  - the alusrcb and pcsource encodings.
- Sub-module mc_cu_dec: a purely combinational instruction decoder producing the one-hot i_* signals and a legal flag. It is reusable by the single-cycle unit.

Test Plan:
- add, MEM_HANDSHAKE=1, mem_rdy=1 always -> states 0,1,2,4,0; wreg=1 only in WB; icount 0->1.
- lw with mem_rdy low for 3 cycles in MEM -> MEM held 4 cycles, mem_req=1, iord=1; WB then has m2reg=1, regrt=1, wreg=1; icount=1.
- beq with z=1 -> wpc=1 and pcsource=01 in EXE; beq with z=0 -> wpc=0; bne with z=0 -> wpc=1; icount increments each time.
- jal -> in ID: wpc=1, pcsource=11, wreg=1, jal=1; 2 cycles total; next state IF.
- op=6'b111111 -> ill=1 for one cycle in ID, no write enable asserted, icount unchanged.
- TMO_W=4, mem_rdy held 0 in IF -> tmo=1 on the 15th wait cycle, state stays IF with the watchdog cleared; resetn pulsed low during MEM -> state=0 and all enables 0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS32 subset encodings: opcodes, funcs, ALU controls, mux selects
// and the multi-cycle control FSM states.
package mips_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUC_W  = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0e;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  localparam logic [OP_W-1:0] FN_SLL = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL = 6'h02;
  localparam logic [OP_W-1:0] FN_SRA = 6'h03;
  localparam logic [OP_W-1:0] FN_JR  = 6'h08;
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR = 6'h26;

  localparam logic [ALUC_W-1:0] ALUC_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALUC_SUB = 4'b0100;
  localparam logic [ALUC_W-1:0] ALUC_AND = 4'b0001;
  localparam logic [ALUC_W-1:0] ALUC_OR  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALUC_XOR = 4'b0010;
  localparam logic [ALUC_W-1:0] ALUC_LUI = 4'b0110;
  localparam logic [ALUC_W-1:0] ALUC_SLL = 4'b0011;
  localparam logic [ALUC_W-1:0] ALUC_SRL = 4'b0111;
  localparam logic [ALUC_W-1:0] ALUC_SRA = 4'b1111;

  localparam logic [STATE_W-1:0] S_IF  = 3'd0;
  localparam logic [STATE_W-1:0] S_ID  = 3'd1;
  localparam logic [STATE_W-1:0] S_EXE = 3'd2;
  localparam logic [STATE_W-1:0] S_MEM = 3'd3;
  localparam logic [STATE_W-1:0] S_WB  = 3'd4;

  localparam logic [1:0] ASRCB_REG  = 2'b00;
  localparam logic [1:0] ASRCB_FOUR = 2'b01;
  localparam logic [1:0] ASRCB_IMM  = 2'b10;
  localparam logic [1:0] ASRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_RS  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

  typedef struct packed {
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
    logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui;
    logic i_j, i_jal;
  } inst_t;

  function automatic logic [ALUC_W-1:0] alu_ctrl(input inst_t i);
    if (i.i_sub || i.i_beq || i.i_bne) return ALUC_SUB;
    if (i.i_and || i.i_andi)            return ALUC_AND;
    if (i.i_or  || i.i_ori)             return ALUC_OR;
    if (i.i_xor || i.i_xori)            return ALUC_XOR;
    if (i.i_lui)                        return ALUC_LUI;
    if (i.i_sll)                        return ALUC_SLL;
    if (i.i_srl)                        return ALUC_SRL;
    if (i.i_sra)                        return ALUC_SRA;
    return ALUC_ADD;
  endfunction

  // Instructions whose second ALU operand is the extended immediate
  function automatic logic is_imm(input inst_t i);
    return i.i_addi | i.i_andi | i.i_ori | i.i_xori | i.i_lui | i.i_lw | i.i_sw;
  endfunction

  function automatic logic sign_ext(input inst_t i);
    return i.i_addi | i.i_lw | i.i_sw | i.i_beq | i.i_bne;
  endfunction

  function automatic logic dest_rt(input inst_t i);
    return i.i_addi | i.i_andi | i.i_ori | i.i_xori | i.i_lw | i.i_lui;
  endfunction

endpackage

// File: rtl/mc_cu_if.sv
// Instruction/flag inputs and datapath control outputs of the multi-cycle control unit.
interface mc_cu_if;
  import mips_pkg::*;

  logic [OP_W-1:0]   op;
  logic [OP_W-1:0]   func;
  logic              z;
  logic              mem_rdy;
  logic              mem_req;
  logic              iord;
  logic              wmem;
  logic              wir;
  logic              wpc;
  logic              wreg;
  logic              regrt;
  logic              m2reg;
  logic              shift;
  logic              sext;
  logic              jal;
  logic              alusrca;
  logic [1:0]        alusrcb;
  logic [ALUC_W-1:0] aluc;
  logic [1:0]        pcsource;

  modport master (
    input  op, func, z, mem_rdy,
    output mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, shift, sext, jal,
           alusrca, alusrcb, aluc, pcsource
  );

  modport slave (
    output op, func, z, mem_rdy,
    input  mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, shift, sext, jal,
           alusrca, alusrcb, aluc, pcsource
  );
endinterface

// File: rtl/mc_cu_dec.sv
// Combinational MIPS32 subset decoder: one-hot instruction flags plus a legal flag.
module mc_cu_dec
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] func,
  output inst_t           inst,
  output logic            legal
);

  logic r_type;

  always_comb begin
    inst   = '0;
    r_type = (op == OP_RTYPE);

    inst.i_add  = r_type && (func == FN_ADD);
    inst.i_sub  = r_type && (func == FN_SUB);
    inst.i_and  = r_type && (func == FN_AND);
    inst.i_or   = r_type && (func == FN_OR);
    inst.i_xor  = r_type && (func == FN_XOR);
    inst.i_sll  = r_type && (func == FN_SLL);
    inst.i_srl  = r_type && (func == FN_SRL);
    inst.i_sra  = r_type && (func == FN_SRA);
    inst.i_jr   = r_type && (func == FN_JR);

    inst.i_addi = (op == OP_ADDI);
    inst.i_andi = (op == OP_ANDI);
    inst.i_ori  = (op == OP_ORI);
    inst.i_xori = (op == OP_XORI);
    inst.i_lw   = (op == OP_LW);
    inst.i_sw   = (op == OP_SW);
    inst.i_beq  = (op == OP_BEQ);
    inst.i_bne  = (op == OP_BNE);
    inst.i_lui  = (op == OP_LUI);
    inst.i_j    = (op == OP_J);
    inst.i_jal  = (op == OP_JAL);

    legal = |inst;
  end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS32 control unit: IF/ID/EXE/MEM/WB sequencer with memory
// handshake, wait watchdog, illegal-instruction pulse and retire counter.
module mc_cu
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned TMO_W         = 4
) (
  input  logic               clock,
  input  logic               resetn,
  mc_cu_if.master            bus,
  output logic [STATE_W-1:0] state,
  output logic               ill,
  output logic               tmo,
  output logic [CNT_W-1:0]   icount
);

  // Expiry is flagged on the wait cycle that brings the count to 2^TMO_W-1
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  logic [STATE_W-1:0] state_q, next_state;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic [CNT_W-1:0]   icount_q;
  inst_t              inst;
  logic               legal, rdy, retire, waiting, take;

  logic              mem_req_c, iord_c, wmem_c, wir_c, wpc_c, wreg_c;
  logic              regrt_c, m2reg_c, shift_c, sext_c, jal_c, alusrca_c;
  logic [1:0]        alusrcb_c, pcsource_c;
  logic [ALUC_W-1:0] aluc_c;
  logic              ill_c, tmo_c;

  mc_cu_dec u_dec (
    .op    (bus.op),
    .func  (bus.func),
    .inst  (inst),
    .legal (legal)
  );

  assign rdy = MEM_HANDSHAKE ? bus.mem_rdy : 1'b1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IF;
      wdog_q   <= '0;
      icount_q <= '0;
    end else begin
      state_q <= next_state;
      wdog_q  <= wdog_d;
      if (retire) icount_q <= icount_q + CNT_W'(1);
    end
  end

  // Next state and all control outputs; everything stays 0 while in reset
  always_comb begin
    next_state = state_q;
    wdog_d     = '0;
    retire     = 1'b0;
    waiting    = 1'b0;
    take       = 1'b0;
    mem_req_c  = 1'b0;
    iord_c     = 1'b0;
    wmem_c     = 1'b0;
    wir_c      = 1'b0;
    wpc_c      = 1'b0;
    wreg_c     = 1'b0;
    regrt_c    = 1'b0;
    m2reg_c    = 1'b0;
    shift_c    = 1'b0;
    sext_c     = 1'b0;
    jal_c      = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = ASRCB_REG;
    aluc_c     = ALUC_ADD;
    pcsource_c = PCSRC_ALU;
    ill_c      = 1'b0;
    tmo_c      = 1'b0;

    if (resetn) begin
      case (state_q)
        S_IF: begin
          mem_req_c = 1'b1;
          alusrcb_c = ASRCB_FOUR;
          if (rdy) begin
            wir_c      = 1'b1;
            wpc_c      = 1'b1;
            next_state = S_ID;
          end
        end
        S_ID: begin
          alusrcb_c = ASRCB_IMM4;
          sext_c    = sign_ext(inst);
          if (!legal) begin
            ill_c      = 1'b1;
            next_state = S_IF;
          end else if (inst.i_j || inst.i_jal) begin
            wpc_c      = 1'b1;
            pcsource_c = PCSRC_JMP;
            wreg_c     = inst.i_jal;
            jal_c      = inst.i_jal;
            retire     = 1'b1;
            next_state = S_IF;
          end else if (inst.i_jr) begin
            wpc_c      = 1'b1;
            pcsource_c = PCSRC_RS;
            retire     = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_EXE;
          end
        end
        S_EXE: begin
          alusrca_c = 1'b1;
          alusrcb_c = is_imm(inst) ? ASRCB_IMM : ASRCB_REG;
          aluc_c    = alu_ctrl(inst);
          shift_c   = inst.i_sll | inst.i_srl | inst.i_sra;
          sext_c    = sign_ext(inst);
          if (inst.i_beq || inst.i_bne) begin
            take       = (inst.i_beq && bus.z) || (inst.i_bne && !bus.z);
            wpc_c      = take;
            pcsource_c = take ? PCSRC_BR : PCSRC_ALU;
            retire     = 1'b1;
            next_state = S_IF;
          end else if (inst.i_lw || inst.i_sw) begin
            next_state = S_MEM;
          end else begin
            next_state = S_WB;
          end
        end
        S_MEM: begin
          mem_req_c = 1'b1;
          iord_c    = 1'b1;
          wmem_c    = inst.i_sw;
          if (rdy) begin
            retire     = inst.i_sw;
            next_state = inst.i_sw ? S_IF : S_WB;
          end
        end
        S_WB: begin
          wreg_c     = 1'b1;
          regrt_c    = dest_rt(inst);
          m2reg_c    = inst.i_lw;
          retire     = 1'b1;
          next_state = S_IF;
        end
        default: next_state = S_IF;
      endcase

      // Watchdog: abandon a stalled access and refetch
      waiting = mem_req_c && !rdy;
      if (MEM_HANDSHAKE && waiting) begin
        if (wdog_q == TMO_LAST) begin
          tmo_c      = 1'b1;
          wmem_c     = 1'b0;
          wir_c      = 1'b0;
          wpc_c      = 1'b0;
          wreg_c     = 1'b0;
          retire     = 1'b0;
          next_state = S_IF;
        end else begin
          wdog_d = wdog_q + TMO_W'(1);
        end
      end
    end
  end

  assign bus.mem_req  = mem_req_c;
  assign bus.iord     = iord_c;
  assign bus.wmem     = wmem_c;
  assign bus.wir      = wir_c;
  assign bus.wpc      = wpc_c;
  assign bus.wreg     = wreg_c;
  assign bus.regrt    = regrt_c;
  assign bus.m2reg    = m2reg_c;
  assign bus.shift    = shift_c;
  assign bus.sext     = sext_c;
  assign bus.jal      = jal_c;
  assign bus.alusrca  = alusrca_c;
  assign bus.alusrcb  = alusrcb_c;
  assign bus.aluc     = aluc_c;
  assign bus.pcsource = pcsource_c;
  assign ill          = ill_c;
  assign tmo          = tmo_c;
  assign state        = state_q;
  assign icount       = icount_q;

endmodule
